// File: rtl/dt.sv
// rtl/dt.sv - two-pass chessboard distance transform engine, 128x128 image (optional SKIP_BG_EN)
module dt #(
    parameter int IMG_W  = 128,
    parameter int DIST_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    output logic              sti_rd,
    output logic [9:0]        sti_addr,
    input  logic [15:0]       sti_di,
    output logic              res_rd,
    output logic              res_wr,
    output logic [13:0]       res_addr,
    output logic [DIST_W-1:0] res_do,
    input  logic [DIST_W-1:0] res_di,
    output logic              fwpass_finish,
    output logic              done
);

    localparam logic [6:0]  LAST_RC  = 7'(IMG_W - 1);
    localparam logic [13:0] LAST_PIX = 14'(IMG_W * IMG_W - 1);

`ifdef SKIP_BG_EN
    // Background writes are dropped and all-zero ROM words are skipped whole.
    localparam logic SKIP_BG = 1'b1;
`else
    localparam logic SKIP_BG = 1'b0;
`endif

    typedef enum logic [3:0] {
        IDLE,
        FW_LDW,
        FW_RD,
        FW_WR,
        FW_FIN,
        BW_LDW,
        BW_RD,
        BW_WR,
        DONE
    } state_t;

    state_t            state_q;
    logic [13:0]       p_q;
    logic [15:0]       word_q;
    logic [2:0]        idx_q;
    logic              nbv_q;
    logic [DIST_W-1:0] min_q;
    logic [DIST_W-1:0] cur_q;

    logic              sti_rd_q;
    logic [9:0]        sti_addr_q;
    logic              res_rd_q;
    logic              res_wr_q;
    logic [13:0]       res_addr_q;
    logic [DIST_W-1:0] res_do_q;
    logic              fin_q;
    logic              done_q;

    logic              fw_pass_d;
    logic              ldw_d;
    logic              word_zero_d;
    logic [13:0]       adv_p_d;
    logic [3:0]        bidx_d;
    logic              disp_bit_d;
    logic              disp_en_d;
    logic [DIST_W-1:0] samp_d;
    logic [DIST_W-1:0] min_d;
    logic [DIST_W-1:0] fw_val_d;
    logic [DIST_W-1:0] bw_inc_d;
    logic [DIST_W-1:0] bw_val_d;
    logic [14:0]       first_nb_d;
    logic [14:0]       next_nb_d;

    // Neighbour address for read slot idx of pixel p; {valid, addr}.
    // Forward slots: NW, N, NE, W.  Backward slots: cur, E, SW, S, SE.
    // An out-of-image neighbour returns valid=0 and the pixel's own address,
    // so the address bus never wraps around the array.
    function automatic logic [14:0] nb_sel(input logic fw, input logic [2:0] idx,
                                           input logic [13:0] p);
        logic [6:0]  r;
        logic [6:0]  c;
        logic        v;
        logic [13:0] a;
        r = p[13:7];
        c = p[6:0];
        v = 1'b0;
        a = p;
        if (fw) begin
            case (idx)
                3'd0:    begin v = (r != 7'd0) && (c != 7'd0);    a = p - 14'd129; end
                3'd1:    begin v = (r != 7'd0);                   a = p - 14'd128; end
                3'd2:    begin v = (r != 7'd0) && (c != LAST_RC); a = p - 14'd127; end
                default: begin v = (c != 7'd0);                   a = p - 14'd1;   end
            endcase
        end else begin
            case (idx)
                3'd0:    begin v = 1'b1;                                a = p;           end
                3'd1:    begin v = (c != LAST_RC);                      a = p + 14'd1;   end
                3'd2:    begin v = (r != LAST_RC) && (c != 7'd0);       a = p + 14'd127; end
                3'd3:    begin v = (r != LAST_RC);                      a = p + 14'd128; end
                default: begin v = (r != LAST_RC) && (c != LAST_RC);    a = p + 14'd129; end
            endcase
        end
        if (!v) begin
            a = p;
        end
        return {v, a};
    endfunction

    // Next-pixel selection, dispatch decision and min/+1 datapath.
    always_comb begin
        fw_pass_d   = (state_q == FW_LDW) || (state_q == FW_RD) || (state_q == FW_WR);
        ldw_d       = (state_q == FW_LDW) || (state_q == BW_LDW);
        word_zero_d = SKIP_BG && (sti_di == 16'h0000);

        case (state_q)
            FW_WR:   adv_p_d = p_q + 14'd1;
            BW_WR:   adv_p_d = p_q - 14'd1;
            default: adv_p_d = p_q;
        endcase

        // Bit 15 of a ROM word is the leftmost pixel of its 16-pixel group.
        bidx_d     = ~adv_p_d[3:0];
        disp_bit_d = ldw_d ? sti_di[bidx_d] : word_q[bidx_d];

        case (state_q)
            FW_LDW:  disp_en_d = !word_zero_d;
            FW_WR:   disp_en_d = (p_q != LAST_PIX) && (p_q[3:0] != 4'hF);
            BW_LDW:  disp_en_d = !word_zero_d;
            BW_WR:   disp_en_d = (p_q != 14'd0) && (p_q[3:0] != 4'h0);
            default: disp_en_d = 1'b0;
        endcase

        samp_d   = nbv_q ? res_di : '0;
        min_d    = (samp_d < min_q) ? samp_d : min_q;
        fw_val_d = min_d + DIST_W'(1);
        bw_inc_d = min_d + DIST_W'(1);
        bw_val_d = (cur_q < bw_inc_d) ? cur_q : bw_inc_d;

        first_nb_d = nb_sel(fw_pass_d, 3'd0, adv_p_d);
        next_nb_d  = nb_sel(fw_pass_d, idx_q + 3'd1, p_q);
    end

    // Pass sequencer: word fetch, neighbour reads, write-back, pass handover.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            p_q        <= '0;
            word_q     <= '0;
            idx_q      <= '0;
            nbv_q      <= 1'b0;
            min_q      <= '0;
            cur_q      <= '0;
            sti_rd_q   <= 1'b0;
            sti_addr_q <= '0;
            res_rd_q   <= 1'b0;
            res_wr_q   <= 1'b0;
            res_addr_q <= '0;
            res_do_q   <= '0;
            fin_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            sti_rd_q <= 1'b0;
            res_rd_q <= 1'b0;
            res_wr_q <= 1'b0;
            fin_q    <= 1'b0;

            case (state_q)
                IDLE: begin
                    p_q        <= '0;
                    sti_addr_q <= '0;
                    sti_rd_q   <= 1'b1;
                    state_q    <= FW_LDW;
                end

                FW_LDW: begin
                    word_q <= sti_di;
                    if (word_zero_d) begin
                        if (p_q[13:4] == 10'h3FF) begin
                            state_q <= FW_FIN;
                            fin_q   <= 1'b1;
                        end else begin
                            p_q        <= p_q + 14'd16;
                            sti_addr_q <= p_q[13:4] + 10'd1;
                            sti_rd_q   <= 1'b1;
                        end
                    end
                end

                FW_RD: begin
                    min_q <= min_d;
                    if (idx_q == 3'd3) begin
                        state_q    <= FW_WR;
                        res_wr_q   <= 1'b1;
                        res_addr_q <= p_q;
                        res_do_q   <= fw_val_d;
                    end else begin
                        idx_q      <= idx_q + 3'd1;
                        res_rd_q   <= next_nb_d[14];
                        nbv_q      <= next_nb_d[14];
                        res_addr_q <= next_nb_d[13:0];
                    end
                end

                FW_WR: begin
                    if (p_q == LAST_PIX) begin
                        state_q <= FW_FIN;
                        fin_q   <= 1'b1;
                    end else if (p_q[3:0] == 4'hF) begin
                        p_q        <= p_q + 14'd1;
                        sti_addr_q <= p_q[13:4] + 10'd1;
                        sti_rd_q   <= 1'b1;
                        state_q    <= FW_LDW;
                    end
                end

                FW_FIN: begin
                    p_q        <= LAST_PIX;
                    sti_addr_q <= 10'h3FF;
                    sti_rd_q   <= 1'b1;
                    state_q    <= BW_LDW;
                end

                BW_LDW: begin
                    word_q <= sti_di;
                    if (word_zero_d) begin
                        if (p_q[13:4] == 10'h000) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            p_q        <= p_q - 14'd16;
                            sti_addr_q <= p_q[13:4] - 10'd1;
                            sti_rd_q   <= 1'b1;
                        end
                    end
                end

                BW_RD: begin
                    // Slot 0 returns the forward result and is kept apart from the min.
                    if (idx_q == 3'd0) begin
                        cur_q <= res_di;
                    end else begin
                        min_q <= min_d;
                    end
                    if (idx_q == 3'd4) begin
                        state_q    <= BW_WR;
                        res_wr_q   <= 1'b1;
                        res_addr_q <= p_q;
                        res_do_q   <= bw_val_d;
                    end else begin
                        idx_q      <= idx_q + 3'd1;
                        res_rd_q   <= next_nb_d[14];
                        nbv_q      <= next_nb_d[14];
                        res_addr_q <= next_nb_d[13:0];
                    end
                end

                BW_WR: begin
                    if (p_q == 14'd0) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else if (p_q[3:0] == 4'h0) begin
                        p_q        <= p_q - 14'd1;
                        sti_addr_q <= p_q[13:4] - 10'd1;
                        sti_rd_q   <= 1'b1;
                        state_q    <= BW_LDW;
                    end
                end

                DONE: begin
                    state_q <= DONE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase

            // Start the next pixel: objects go to neighbour reads, background
            // goes straight to the write slot (write suppressed where not needed).
            if (disp_en_d) begin
                p_q        <= adv_p_d;
                idx_q      <= '0;
                min_q      <= '1;
                res_addr_q <= adv_p_d;
                res_do_q   <= '0;
                if (disp_bit_d) begin
                    state_q    <= fw_pass_d ? FW_RD : BW_RD;
                    res_rd_q   <= first_nb_d[14];
                    nbv_q      <= first_nb_d[14];
                    res_addr_q <= first_nb_d[13:0];
                end else begin
                    state_q  <= fw_pass_d ? FW_WR : BW_WR;
                    res_wr_q <= fw_pass_d && !SKIP_BG;
                end
            end
        end
    end

    assign sti_rd        = sti_rd_q;
    assign sti_addr      = sti_addr_q;
    assign res_rd        = res_rd_q;
    assign res_wr        = res_wr_q;
    assign res_addr      = res_addr_q;
    assign res_do        = res_do_q;
    assign fwpass_finish = fin_q;
    assign done          = done_q;

endmodule

// File: tb/tb_dt.sv
// tb/tb_dt.sv - scoreboard testbench for the dt distance transform engine
module tb_dt;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sti_rd;
    logic [9:0]  sti_addr;
    logic [15:0] sti_di = '0;
    logic        res_rd;
    logic        res_wr;
    logic [13:0] res_addr;
    logic [7:0]  res_do;
    logic [7:0]  res_di = '0;
    logic        fwpass_finish;
    logic        done;

    dt dut (
        .clk           (clk),
        .reset         (reset),
        .sti_rd        (sti_rd),
        .sti_addr      (sti_addr),
        .sti_di        (sti_di),
        .res_rd        (res_rd),
        .res_wr        (res_wr),
        .res_addr      (res_addr),
        .res_do        (res_do),
        .res_di        (res_di),
        .fwpass_finish (fwpass_finish),
        .done          (done)
    );

    always #5 clk = ~clk;

    logic [7:0]  ram [16384];
    logic [15:0] rom [1024];
    logic [7:0]  exp_fw [16384];
    logic [7:0]  exp_bw [16384];
    logic        ram_clr = 1'b1;

    logic [21:0] fw_q [$];
    logic [21:0] bw_q [$];

    int vectors = 0;
    int errors = 0;
    int fin_cnt = 0;
    int done_rises = 0;

    localparam logic [7:0] B3_FW [9]  = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd2, 8'd1, 8'd1, 8'd2, 8'd1};
    localparam logic [7:0] B3_BW [9]  = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd2, 8'd1, 8'd1, 8'd1, 8'd1};
    localparam logic [7:0] B5_FW [25] = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1,
                                          8'd1, 8'd2, 8'd2, 8'd2, 8'd1,
                                          8'd1, 8'd2, 8'd3, 8'd2, 8'd1,
                                          8'd1, 8'd2, 8'd3, 8'd2, 8'd1,
                                          8'd1, 8'd2, 8'd3, 8'd2, 8'd1};
    localparam logic [7:0] B5_BW [25] = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1,
                                          8'd1, 8'd2, 8'd2, 8'd2, 8'd1,
                                          8'd1, 8'd2, 8'd3, 8'd2, 8'd1,
                                          8'd1, 8'd2, 8'd2, 8'd2, 8'd1,
                                          8'd1, 8'd1, 8'd1, 8'd1, 8'd1};

    // RAM: commit on posedge, read data appears on the negedge after res_rd.
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 16384; i++) ram[i] <= 8'h00;
        end else if (res_wr) begin
            ram[res_addr] <= res_do;
        end
    end

    always @(negedge clk) begin
        if (sti_rd) sti_di <= rom[sti_addr];
        if (res_rd) res_di <= ram[res_addr];
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
        vectors++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, expv);
        end
    endtask

    task automatic chk_ram(input string tag, input int p, input logic [7:0] got, input logic [7:0] expv);
        vectors++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s addr %0d (r%0d c%0d): got %0d expected %0d", tag, p, p / 128, p % 128, got, expv);
        end
    endtask

    task automatic put(input int r, input int c, input logic [7:0] f, input logic [7:0] b);
        exp_fw[r * 128 + c] = f;
        exp_bw[r * 128 + c] = b;
    endtask

    task automatic build_image(input bit objs);
        for (int p = 0; p < 16384; p++) begin
            exp_fw[p] = 8'd0;
            exp_bw[p] = 8'd0;
        end
        if (objs) begin
            put(64, 64, 8'd1, 8'd1);
            put(1, 126, 8'd1, 8'd1);
            put(126, 1, 8'd1, 8'd1);
            put(0, 0, 8'd1, 8'd1);
            put(127, 127, 8'd1, 8'd1);
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    put(10 + i, 10 + j, B3_FW[i * 3 + j], B3_BW[i * 3 + j]);
            for (int i = 0; i < 5; i++)
                for (int j = 0; j < 5; j++)
                    put(20 + i, 20 + j, B5_FW[i * 5 + j], B5_BW[i * 5 + j]);
        end
        for (int w = 0; w < 1024; w++)
            for (int b = 0; b < 16; b++)
                rom[w][15 - b] = (exp_fw[w * 16 + b] != 8'd0);
    endtask

    task automatic push_expected();
        fw_q.delete();
        bw_q.delete();
        for (int p = 0; p < 16384; p++)
            if (exp_fw[p] != 8'd0) fw_q.push_back({14'(p), exp_fw[p]});
        for (int p = 16383; p >= 0; p--)
            if (exp_bw[p] != 8'd0) bw_q.push_back({14'(p), exp_bw[p]});
    endtask

    // Monitor: checks every RAM write against the scoreboard and pass events.
    initial begin : monitor
        bit          in_bw;
        bit          seen_done;
        bit          prev_fin;
        bit          prev_done;
        logic [21:0] e;
        in_bw = 0; seen_done = 0; prev_fin = 0; prev_done = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                in_bw = 0; seen_done = 0; prev_fin = 0; prev_done = 0;
                fin_cnt = 0; done_rises = 0;
            end else begin
                if (seen_done) chk("idle_after_done", {sti_rd, res_rd, res_wr}, 0);
                if (fwpass_finish) begin
                    fin_cnt++;
                    chk("fin_single_cycle", prev_fin, 0);
                    chk("fin_no_write", res_wr, 0);
                    chk("fw_queue_drained", fw_q.size(), 0);
                    for (int p = 0; p < 16384; p++) chk_ram("fw_ram", p, ram[p], exp_fw[p]);
                    in_bw = 1;
                end
                if (res_wr) begin
                    chk("rd_wr_exclusive", res_rd, 0);
                    if (!in_bw) begin
                        if (exp_fw[res_addr] != 8'd0) begin
                            if (fw_q.size() == 0) begin
                                vectors++; errors++;
                                $display("FAIL fw_extra_write: got addr %0d data %0d expected none", res_addr, res_do);
                            end else begin
                                e = fw_q.pop_front();
                                chk("fw_write", {res_addr, res_do}, e);
                            end
                        end else begin
                            chk("fw_bg_write", res_do, 0);
                        end
                    end else begin
                        if (bw_q.size() == 0) begin
                            vectors++; errors++;
                            $display("FAIL bw_extra_write: got addr %0d data %0d expected none", res_addr, res_do);
                        end else begin
                            e = bw_q.pop_front();
                            chk("bw_write", {res_addr, res_do}, e);
                        end
                    end
                end
                if (done && !prev_done) begin
                    done_rises++;
                    seen_done = 1;
                end
                prev_fin  = fwpass_finish;
                prev_done = done;
            end
        end
    end

    task automatic run(input bit abort);
        bit ok;
        push_expected();
        @(negedge clk);
        reset = 1'b0;
        if (abort) begin
            ok = 0;
            for (int i = 0; i < 40000 && !ok; i++) begin
                @(negedge clk);
                if (res_wr && res_addr == 14'(20 * 128 + 22)) ok = 1;
            end
            chk("abort_point_reached", ok, 1);
            chk("abort_before_fin", fin_cnt, 0);
            @(posedge clk);
            #2 reset = 1'b1;
            #1 chk("async_reset_outputs",
                   {sti_rd, res_rd, res_wr, fwpass_finish, done, sti_addr, res_addr, res_do}, 0);
            repeat (2) @(negedge clk);
            push_expected();
            @(negedge clk);
            reset = 1'b0;
        end
        ok = 0;
        for (int i = 0; i < 60000 && !ok; i++) begin
            @(negedge clk);
            ok = done;
        end
        chk("done_within_budget", ok, 1);
        repeat (20) @(negedge clk);
        chk("done_held", done, 1);
        chk("fin_pulse_count", fin_cnt, 1);
        chk("done_rise_count", done_rises, 1);
        chk("bw_queue_drained", bw_q.size(), 0);
        for (int p = 0; p < 16384; p++) chk_ram("bw_ram", p, ram[p], exp_bw[p]);
    endtask

    initial begin
        reset   = 1'b1;
        ram_clr = 1'b1;
        build_image(1'b0);
        repeat (3) @(negedge clk);
        ram_clr = 1'b0;
        @(negedge clk);
        chk("reset_outputs",
            {sti_rd, res_rd, res_wr, fwpass_finish, done, sti_addr, res_addr, res_do}, 0);

        // All-background image.
        run(1'b0);

        // Reset before the next run, then objects with a mid-forward abort.
        @(negedge clk);
        reset = 1'b1;
        build_image(1'b1);
        repeat (2) @(negedge clk);
        chk("reset_clears_done", done, 0);
        run(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/dt.md
Name: dt

Overview:
- Two-pass chessboard (8-connected) distance transform engine for a 128x128 binary image.
- Reads the packed binary image from a 16-bit-wide source ROM.
- Runs a forward raster pass, then a backward raster pass, into an 8-bit-per-pixel result RAM.
- Signals completion of each pass to the system controller.

Parameters:
- IMG_W, 128, image width/height in pixels (fixed square image; only 128 supported).
- DIST_W, 8, distance value width.

Ports:
- clk  input  1  system clock; all DUT logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- sti_rd  output  1  source ROM read enable.
- sti_addr  output  10  source ROM word address = row*8 + col/16.
- sti_di  input  16  ROM word, updated on negedge after sti_rd; bit 15 = leftmost pixel (col%16==0).
- res_rd  output  1  result RAM read enable.
- res_wr  output  1  result RAM write enable; write occurs on posedge.
- res_addr  output  14  pixel address = row*128 + col.
- res_do  output  8  write data to RAM.
- res_di  input  8  RAM read data, updated on negedge after res_rd.
- fwpass_finish  output  1  one-cycle pulse when the forward pass is fully written.
- done  output  1  high when the backward pass is complete; held until reset.

Behaviour:
- Reset state:
  - All outputs 0; FSM in IDLE.
  - Reset mid-operation aborts immediately; the next run restarts from pixel 0.
- Start: the first clock after reset deasserts leaves IDLE and starts the forward pass.
- Memory timing:
  - Drive address and rd on a posedge; sample sti_di/res_di on the following posedge (1-cycle read latency).
  - Write: drive res_addr, res_do and res_wr=1 for one cycle; the RAM commits on the next posedge.
- Pixel p=(r,c): object if its ROM bit is 1, background if 0. Out-of-image neighbours read as 0, with no RAM access.
- Forward pass, raster order p=0..16383:
  - Background: write 0.
  - Object: write 1 + min(NW, N, NE, W), using RAM values already written in this pass.
  - One ROM read per 16-pixel word; keep the word in a shift/index register.
- After the last forward write has committed, pulse fwpass_finish for exactly 1 cycle. No RAM writes occur in that cycle.
- Backward pass, order p=16383 down to 0:
  - Background: no write.
  - Object: write min(cur, 1 + min(E, SW, S, SE)). Neighbours are RAM values already updated in this pass; cur is the forward result.
  - The ROM is re-read to identify object pixels.
- After the last backward write commits, set done=1 and keep it until reset. Enter the DONE state; no further memory activity.
- Arithmetic: min over unsigned 8-bit values; the +1 never overflows (max distance 64).
- FSM states: IDLE, FW_LDW (ROM fetch), FW_RD (4 neighbour reads, 1 per cycle), FW_WR, FW_FIN, BW_LDW, BW_RD (cur + 4 neighbours), BW_WR, DONE.
- Single-port RAM: res_rd and res_wr are never high in the same cycle.
- sti_rd is high only in fetch cycles.
- Total run must finish within 10^8 cycles at an 11 ns clock (target < 250k cycles).

Optional Feature:
- Macro: SKIP_BG_EN.
- Defined:
  - Forward pass skips the RAM write for background pixels; the RAM is relied on to power up/clear to 0.
  - Any all-zero ROM word skips its 16 pixels in one step, in both passes.
  - Final RAM contents are identical to the undefined case; cycle count is lower.
- Undefined:
  - Every pixel is written in the forward pass.
  - Every pixel is visited individually.

Test Plan:
- All-zero image:
  - Every RAM location = 0 after fwpass_finish and after done.
  - fwpass_finish pulses exactly once before done rises.
- Single object pixel at (64,64), address 8256: forward=1, backward=1; all other locations 0.
- 3x3 block rows/cols 10..12:
  - Forward: row 10 = 1,1,1; row 11 = 1,2,1; row 12 = 1,2,1.
  - Backward: border 1, centre (11,11)=2.
- 5x5 block rows/cols 20..24: after done, ring 1 = 1, ring 2 = 2, centre (22,22) = 3.
- Pixels at (1,126) and (126,1): forward and backward value 1.
  - Adjacent out-of-image neighbours read as 0.
  - No res_addr wrap beyond 16383 or below 0.
- Reset asserted mid-forward-pass, then released:
  - Outputs go to 0 asynchronously.
  - The run restarts at pixel 0 and the final RAM matches the golden result.
  - done rises exactly once.
